// File: rtl/pwm_deadtime_if.sv
// pwm_deadtime_if: groups the PWM-side request/config inputs and the gate-side
// outputs of the dead-time inserter.
//   master: drives pwmin, dtce, deadtime, faultclr; observes the gate/status outputs
//   slave : the dead-time inserter itself
interface pwm_deadtime_if #(
  parameter int DTW = 8
);
  logic [1:0]     pwmin;     // [0] high-side request, [1] low-side request
  logic           dtce;      // dead-time tick enable
  logic [DTW-1:0] deadtime;  // dead interval length in dtce ticks
  logic           faultclr;  // clears latched fault (latching build only)
  logic           gatehi;    // high-side gate drive
  logic           gatelo;    // low-side gate drive
  logic           indead;    // dead interval in progress
  logic           fault;     // shoot-through present/latched

  modport master (
    output pwmin, dtce, deadtime, faultclr,
    input  gatehi, gatelo, indead, fault
  );

  modport slave (
    input  pwmin, dtce, deadtime, faultclr,
    output gatehi, gatelo, indead, fault
  );
endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: break-before-make dead-time inserter for a complementary PWM pair.
// One gate is always held off for deadtime+1 clocks (dtce continuous) before the
// other turns on; an illegal request pair (both on) forces both gates off.
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - pwm_deadtime_if.slave: pwmin/dtce/deadtime/faultclr in,
//            gatehi/gatelo/indead/fault out
// Build option: define DT_SHOOTTHRU_LATCH_EN to make a shoot-through request
// latch a FAULT state that only faultclr (with a legal request) releases.
module pwm_deadtime #(
  parameter int DTW = 8
) (
  input  logic             clk,
  input  logic             resetn,
  pwm_deadtime_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HION  = 3'd1,
    LOON  = 3'd2,
    DTH   = 3'd3,
    DTL   = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     req_q;
  logic [DTW-1:0] dtcnt_q, dtcnt_d;
  logic           gatehi_q, gatelo_q, indead_q, fault_q;
  logic           gatehi_d, gatelo_d, indead_d, fault_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q    <= 2'b00;
      state_q  <= IDLE;
      dtcnt_q  <= '0;
      gatehi_q <= 1'b0;
      gatelo_q <= 1'b0;
      indead_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      req_q    <= bus.pwmin;
      state_q  <= state_d;
      dtcnt_q  <= dtcnt_d;
      gatehi_q <= gatehi_d;
      gatelo_q <= gatelo_d;
      indead_q <= indead_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dtcnt_d = dtcnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_q == 2'b01) begin
          state_d = DTH;
          dtcnt_d = bus.deadtime;
        end else if (req_q == 2'b10) begin
          state_d = DTL;
          dtcnt_d = bus.deadtime;
        end
      end
      HION: begin
        if (req_q == 2'b10) begin
          state_d = DTL;
          dtcnt_d = bus.deadtime;
        end else if (req_q != 2'b01) begin
          state_d = IDLE;
        end
      end
      LOON: begin
        if (req_q == 2'b01) begin
          state_d = DTH;
          dtcnt_d = bus.deadtime;
        end else if (req_q != 2'b10) begin
          state_d = IDLE;
        end
      end
      DTH, DTL: begin
        // Only all-off requests abort the interval; a flip of the legal
        // request neither shortens nor restarts it, and is honoured at exit.
        if (req_q == 2'b00 || req_q == 2'b11) begin
          state_d = IDLE;
        end else if (dtcnt_q == '0) begin
          state_d = (req_q == 2'b01) ? HION : LOON;
        end else if (bus.dtce) begin
          dtcnt_d = dtcnt_q - 1'b1;
        end
      end
      FAULT: begin
`ifdef DT_SHOOTTHRU_LATCH_EN
        if (bus.faultclr && req_q != 2'b11) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef DT_SHOOTTHRU_LATCH_EN
    if (req_q == 2'b11) state_d = FAULT;
`endif
  end

  // Outputs are registered decodes of the next state, so they move with state_q.
  always_comb begin
    gatehi_d = (state_d == HION);
    gatelo_d = (state_d == LOON);
    indead_d = (state_d == DTH) || (state_d == DTL);
`ifdef DT_SHOOTTHRU_LATCH_EN
    fault_d  = (state_d == FAULT);
`else
    fault_d  = (req_q == 2'b11);
`endif
  end

`ifndef DT_SHOOTTHRU_LATCH_EN
  logic unused_faultclr;
  assign unused_faultclr = bus.faultclr;
`endif

  assign bus.gatehi = gatehi_q;
  assign bus.gatelo = gatelo_q;
  assign bus.indead = indead_q;
  assign bus.fault  = fault_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
module tb_pwm_deadtime;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pwm_deadtime_if #(.DTW(8)) bus ();

  pwm_deadtime #(.DTW(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // {gatehi, gatelo, indead, fault}
  logic [3:0] outs;
  assign outs = {bus.gatehi, bus.gatelo, bus.indead, bus.fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset two cycles, release just after an edge; the next edge samples pwmin.
  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  initial begin
    int dead;
    bus.pwmin    = 2'b01;
    bus.dtce     = 1'b1;
    bus.deadtime = 8'd3;
    bus.faultclr = 1'b0;

    // 1: reset with a request present
    step(2);
    check("rst_outs", {28'd0, outs}, 32'h0);
    resetn = 1'b1;
    step(1);
    check("rel_idle", {28'd0, outs}, 32'h0);
    step(1);
    check("rel_dth", {28'd0, outs}, 32'h2);

    // 2: deadtime=3, dtce continuous: indead edges 2..5, gatehi at edge 6
    do_reset();
    step(1);
    check("t2_e1", {28'd0, outs}, 32'h0);
    for (int e = 2; e <= 5; e++) begin
      step(1);
      check("t2_dead", {28'd0, outs}, 32'h2);
    end
    step(1);
    check("t2_hion", {28'd0, outs}, 32'h8);
    step(1);
    check("t2_hold", {28'd0, outs}, 32'h8);

    // 3: HION -> LOON, deadtime=5, dtce on edges 4,8,12,16,20 -> gatelo at edge 21
    bus.deadtime = 8'd5;
    bus.pwmin    = 2'b10;
    bus.dtce     = 1'b0;
    step(1);
    check("t3_f1", {28'd0, outs}, 32'h8);
    step(1);
    check("t3_off", {28'd0, outs}, 32'h2);
    for (int j = 3; j <= 21; j++) begin
      bus.dtce = (j % 4 == 0);
      step(1);
      check("t3_seq", {28'd0, outs}, (j < 21) ? 32'h2 : 32'h4);
    end

    // 4: deadtime=0, toggle every 10 clk: exactly one dead clk per edge, no overlap
    bus.deadtime = 8'd0;
    bus.dtce     = 1'b1;
    for (int seg = 0; seg < 4; seg++) begin
      bus.pwmin = (seg % 2 == 0) ? 2'b01 : 2'b10;
      dead = 0;
      for (int k = 0; k < 10; k++) begin
        step(1);
        check("t4_overlap", {31'd0, bus.gatehi & bus.gatelo}, 32'h0);
        if (bus.indead) dead++;
      end
      check("t4_deadclk", dead, 1);
      check("t4_gate", {28'd0, outs}, (seg % 2 == 0) ? 32'h8 : 32'h4);
    end

    // 5: DTL entered, request flips back to 01 before expiry -> full interval, exit HION
    bus.pwmin    = 2'b01;
    bus.deadtime = 8'd0;
    do_reset();
    step(3);
    check("t5_hion", {28'd0, outs}, 32'h8);
    bus.deadtime = 8'd4;
    bus.pwmin    = 2'b10;
    step(2);
    check("t5_dtl", {28'd0, outs}, 32'h2);
    bus.pwmin = 2'b01;
    for (int e = 3; e <= 6; e++) begin
      step(1);
      check("t5_dead", {28'd0, outs}, 32'h2);
    end
    step(1);
    check("t5_exit", {28'd0, outs}, 32'h8);

    // 6: shoot-through request while LOON
    bus.deadtime = 8'd0;
    bus.pwmin    = 2'b10;
    step(3);
    check("t6_loon", {28'd0, outs}, 32'h4);
    bus.pwmin = 2'b11;
    step(1);
    check("t6_h1", {28'd0, outs}, 32'h4);
    step(1);
    check("t6_fault", {28'd0, outs}, 32'h1);
`ifdef DT_SHOOTTHRU_LATCH_EN
    bus.faultclr = 1'b1;
    step(1);
    check("t6_clr_ign", {28'd0, outs}, 32'h1);
    bus.faultclr = 1'b0;
    bus.pwmin    = 2'b00;
    step(2);
    check("t6_sticky", {28'd0, outs}, 32'h1);
    bus.faultclr = 1'b1;
    step(1);
    check("t6_cleared", {28'd0, outs}, 32'h0);
    bus.faultclr = 1'b0;
`else
    bus.faultclr = 1'b1;
    step(1);
    check("t6_fault2", {28'd0, outs}, 32'h1);
    bus.faultclr = 1'b0;
    bus.pwmin    = 2'b00;
    step(1);
    check("t6_k1", {28'd0, outs}, 32'h1);
    step(1);
    check("t6_drop", {28'd0, outs}, 32'h0);
`endif
    bus.pwmin = 2'b01;
    step(2);
    check("t6_resume", {28'd0, outs}, 32'h2);

    // 7: asynchronous reset mid-interval clears outputs without a clock edge
    bus.deadtime = 8'd10;
    do_reset();
    step(3);
    check("t7_dead", {28'd0, outs}, 32'h2);
    resetn = 1'b0;
    #1;
    check("t7_async", {28'd0, outs}, 32'h0);
    step(1);
    resetn = 1'b1;
    step(1);
    check("t7_idle", {28'd0, outs}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
